hack_data_mem: RTL and testbench
================================

Name: hack_data_mem

Overview:
- Responder side of the Hack CPU data-memory interface. Serves `addressM`/`outM`/`writeM` and returns `inM`.
- Implements the standard Hack memory map:
  - RAM: 0x0000-0x3FFF
  - Screen buffer: 0x4000-0x5FFF
  - Keyboard register: 0x6000
- Adds a registered second read port into the screen buffer for video scanout.
- Adds a valid/ready keyboard ingest path.
- Sits between the CPU and the video/keyboard front-ends in the top-level computer.

Parameters:
- RAM_AW, 14, RAM address width (16384 words)
- SCR_AW, 13, screen buffer address width (8192 words)
- KBD_ADDR, 15'h6000, keyboard register address

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- addressM  input  15  CPU data address
- outM  input  16  CPU write data
- writeM  input  1  CPU write strobe, sampled on clk edge
- inM  output  16  read data to CPU, combinational from addressM
- vid_req  input  1  scanout read request
- vid_addr  input  13  scanout word address
- vid_rvalid  output  1  scanout data valid, one cycle after vid_req
- vid_rdata  output  16  scanout read data
- kbd_valid  input  1  keyboard event valid
- kbd_code  input  16  key code; 0 = all keys released
- kbd_ready  output  1  keyboard event accepted when kbd_valid && kbd_ready

Behaviour:
- **Reset values:** vid_rvalid=0, vid_rdata=0, kbd register=0, kbd FSM=IDLE, kbd_ready=1. RAM and screen contents are not cleared.
- **Address decode** (addressM[14:13]):
  - 00 or 01 -> RAM[addressM[13:0]]
  - 10 -> SCREEN[addressM[12:0]]
  - 11 with addressM==KBD_ADDR -> keyboard register
  - 11 with any other address -> unmapped
- **CPU read:** inM is combinational (zero latency), as the single-cycle CPU requires.
  - Unmapped reads return 16'h0000.
- **CPU write:** when writeM=1 at a clk edge, outM is stored to the decoded RAM/screen word.
  - Writes to KBD_ADDR and to unmapped addresses are ignored.
- **Read-during-write, same address:** inM shows old data in the write cycle and new data from the next cycle.
- **Scanout:** vid_req=1 at edge N -> vid_rvalid=1 and vid_rdata=SCREEN[vid_addr] at N+1.
  - vid_req=0 -> vid_rvalid=0 next cycle; vid_rdata holds its last value.
  - Back-to-back requests give one word per cycle.
- **Scanout vs CPU write, same word, same edge:** vid_rdata returns the old word. No stall; the CPU always has priority.
- **Keyboard FSM**, states IDLE, HELD, COOL:
  - IDLE/HELD, kbd_valid && kbd_code!=0: kbd reg<=kbd_code, go to COOL, then HELD.
  - IDLE/HELD, kbd_valid && kbd_code==0: kbd reg<=0, go to COOL, then IDLE.
  - COOL: kbd_ready=0 for exactly one cycle; events offered in this cycle are not accepted. The source holds kbd_valid until accepted.
  - After COOL, go to HELD if kbd reg!=0, else IDLE.
  - kbd_ready=1 in IDLE and HELD.
- A CPU read of KBD_ADDR in the same cycle as a keyboard accept returns the pre-accept value.
- **Reset mid-operation:** pending vid_rvalid is dropped; the kbd FSM returns to IDLE with reg=0. An in-flight CPU write on the reset edge is still performed, since memory is not reset-gated.

Optional Feature:
- HACK_DATA_MEM_OOB_FLAG_EN
- When defined, adds output `oob_err` (1 bit). It is sticky and is set at the clk edge of any CPU read or write to an unmapped address (addressM in 0x6001-0x7FFF). It is cleared only by reset.
- Without the macro, the port and its logic are absent, and unmapped accesses are silent (read 0, write dropped).

Decomposition:
- **Shared package** (hack_pkg):
  - address constants RAM_BASE, SCR_BASE, KBD_ADDR
  - region-select enum {REG_RAM, REG_SCR, REG_KBD, REG_UNMAPPED}
  - kbd FSM state encoding
- **One natural sub-module:** hack_kbd_latch, containing the keyboard FSM, key register and kbd_ready. The top holds the RAM and screen arrays, the decode, and the scanout port.

Test Plan:
- writeM=1, addressM=0x0005, outM=0x1234; next cycle read 0x0005 -> inM=0x1234. In the write cycle inM still shows the prior value.
- CPU write 0xFFFF to 0x4010; then vid_req=1, vid_addr=0x0010 -> vid_rvalid=1, vid_rdata=0xFFFF one cycle later. Same edge as a write of 0x0F0F to 0x4010 -> vid_rdata=0xFFFF.
- kbd_valid=1, kbd_code=0x0041 -> accepted; kbd_ready=0 for 1 cycle; read 0x6000 -> 0x0041. Then code 0 -> read 0x6000 -> 0x0000, FSM returns to IDLE.
- CPU write 0xBEEF to 0x6000 and to 0x7000 -> reads of 0x6000 unchanged, 0x7000 returns 0; with HACK_DATA_MEM_OOB_FLAG_EN, oob_err=1 after the 0x7000 access.
- Key held (reg=0x0041), vid_req pending, then reset=1 for one cycle -> kbd reg=0, vid_rvalid=0, kbd_ready=1; a RAM word written before reset still reads back.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared constants, region decode and keyboard FSM encoding for the Hack data memory.
package hack_pkg;

    localparam logic [14:0] RAM_BASE = 15'h0000;
    localparam logic [14:0] SCR_BASE = 15'h4000;
    localparam logic [14:0] KBD_ADDR = 15'h6000;

    typedef enum logic [1:0] {REG_RAM, REG_SCR, REG_KBD, REG_UNMAPPED} region_e;

    typedef enum logic [1:0] {KBD_IDLE, KBD_HELD, KBD_COOL} kbd_state_e;

    // Only the top two address bits pick the region; 0x6000 is the sole mapped word above the screen.
    function automatic region_e decode(input logic [14:0] addr, input logic [14:0] kbd_addr);
        region_e r;
        case (addr[14:13])
            2'b00, 2'b01: r = REG_RAM;
            2'b10:        r = REG_SCR;
            default:      r = (addr == kbd_addr) ? REG_KBD : REG_UNMAPPED;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hack_kbd_latch.sv
// Keyboard ingest: latches key codes on a valid/ready handshake, with one cooldown cycle per accept.
module hack_kbd_latch (
    input  logic        clk,
    input  logic        reset,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        kbd_ready,
    output logic [15:0] key
);
    import hack_pkg::*;

    kbd_state_e state, state_next;
    logic       accept;

    assign accept = kbd_valid && kbd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= KBD_IDLE;
            key   <= 16'h0000;
        end else begin
            state <= state_next;
            if (accept) key <= kbd_code;
        end
    end

    always_comb begin
        state_next = state;
        kbd_ready  = 1'b1;
        case (state)
            KBD_IDLE, KBD_HELD: if (kbd_valid) state_next = KBD_COOL;
            KBD_COOL: begin
                kbd_ready  = 1'b0;
                // key already holds the accepted code here, so it decides held vs released
                state_next = (key != 16'h0000) ? KBD_HELD : KBD_IDLE;
            end
            default: state_next = KBD_IDLE;
        endcase
    end

endmodule

// File: rtl/hack_data_mem.sv
// Hack CPU data memory: RAM, screen buffer with a scanout read port, and keyboard register.
// Optional HACK_DATA_MEM_OOB_FLAG_EN adds a sticky oob_err flag for unmapped accesses.
module hack_data_mem #(
    parameter int          RAM_AW   = 14,
    parameter int          SCR_AW   = 13,
    parameter logic [14:0] KBD_ADDR = 15'h6000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [14:0]       addressM,
    input  logic [15:0]       outM,
    input  logic              writeM,
    output logic [15:0]       inM,
    input  logic              vid_req,
    input  logic [SCR_AW-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [15:0]       vid_rdata,
    input  logic              kbd_valid,
    input  logic [15:0]       kbd_code,
    output logic              kbd_ready
`ifdef HACK_DATA_MEM_OOB_FLAG_EN
    ,
    output logic              oob_err
`endif
);
    import hack_pkg::*;

    logic [15:0] ram [2**RAM_AW];
    logic [15:0] scr [2**SCR_AW];
    logic [15:0] key;
    region_e     region;

    assign region = decode(addressM, KBD_ADDR);

    hack_kbd_latch u_kbd (
        .clk       (clk),
        .reset     (reset),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .kbd_ready (kbd_ready),
        .key       (key)
    );

    always_comb begin
        inM = 16'h0000;
        case (region)
            REG_RAM: inM = ram[addressM[RAM_AW-1:0]];
            REG_SCR: inM = scr[addressM[SCR_AW-1:0]];
            REG_KBD: inM = key;
            default: inM = 16'h0000;
        endcase
    end

    // Memory is deliberately not reset-gated: a write on the reset edge still lands.
    always_ff @(posedge clk) begin
        if (writeM) begin
            case (region)
                REG_RAM: ram[addressM[RAM_AW-1:0]] <= outM;
                REG_SCR: scr[addressM[SCR_AW-1:0]] <= outM;
                default: ;
            endcase
        end
    end

    // Non-blocking read against the CPU write gives old data on a same-word collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_rvalid <= 1'b0;
            vid_rdata  <= 16'h0000;
        end else begin
            vid_rvalid <= vid_req;
            if (vid_req) vid_rdata <= scr[vid_addr];
        end
    end

`ifdef HACK_DATA_MEM_OOB_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset)                       oob_err <= 1'b0;
        else if (region == REG_UNMAPPED) oob_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed self-checking bench for hack_data_mem.
module tb_hack_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic        vid_rvalid;
    logic [15:0] vid_rdata;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_ready;
`ifdef HACK_DATA_MEM_OOB_FLAG_EN
    logic        oob_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hack_data_mem dut (
        .clk        (clk),
        .reset      (reset),
        .addressM   (addressM),
        .outM       (outM),
        .writeM     (writeM),
        .inM        (inM),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .kbd_valid  (kbd_valid),
        .kbd_code   (kbd_code),
        .kbd_ready  (kbd_ready)
`ifdef HACK_DATA_MEM_OOB_FLAG_EN
        ,
        .oob_err    (oob_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        addressM = 15'h6000;
        settle();
        tests++; if (vid_rvalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid got %h want 0", vid_rvalid); end
        tests++; if (vid_rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata got %h want 0000", vid_rdata); end
        tests++; if (kbd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %h want 1", kbd_ready); end
        tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL reset_kbd got %h want 0000", inM); end
`ifdef HACK_DATA_MEM_OOB_FLAG_EN
        tests++; if (oob_err !== 1'b0) begin fails++; $display("FAIL reset_oob got %h want 0", oob_err); end
`endif
        tick();
        addressM = 15'h0000;
    endtask

    task automatic test_ram_rw();
        addressM = 15'h0005; outM = 16'h1111; writeM = 1'b1;
        tick();
        outM = 16'h1234;
        settle();
        tests++; if (inM !== 16'h1111) begin fails++; $display("FAIL ram_rdw_old got %h want 1111", inM); end
        tick();
        writeM = 1'b0;
        settle();
        tests++; if (inM !== 16'h1234) begin fails++; $display("FAIL ram_read got %h want 1234", inM); end
        tick();
        // top of RAM and the 0x2000 half (addr bit 13 set) are both RAM
        addressM = 15'h3FFF; outM = 16'hA5A5; writeM = 1'b1;
        tick();
        addressM = 15'h2000; outM = 16'h5A5A;
        tick();
        writeM = 1'b0; addressM = 15'h3FFF;
        settle();
        tests++; if (inM !== 16'hA5A5) begin fails++; $display("FAIL ram_top got %h want a5a5", inM); end
        tick();
        addressM = 15'h2000;
        settle();
        tests++; if (inM !== 16'h5A5A) begin fails++; $display("FAIL ram_2000 got %h want 5a5a", inM); end
        tick();
    endtask

    task automatic test_scanout();
        addressM = 15'h4010; outM = 16'hFFFF; writeM = 1'b1;
        tick();
        addressM = 15'h5FFF; outM = 16'h0BAD;
        tick();
        writeM = 1'b0;
        settle();
        tests++; if (inM !== 16'h0BAD) begin fails++; $display("FAIL scr_top got %h want 0bad", inM); end
        vid_req = 1'b1; vid_addr = 13'h0010;
        tick();
        vid_req = 1'b0;
        settle();
        tests++; if (vid_rvalid !== 1'b1) begin fails++; $display("FAIL vid_rvalid got %h want 1", vid_rvalid); end
        tests++; if (vid_rdata !== 16'hFFFF) begin fails++; $display("FAIL vid_rdata got %h want ffff", vid_rdata); end
        addressM = 15'h4010; outM = 16'h0F0F; writeM = 1'b1; vid_req = 1'b1;
        tick();
        writeM = 1'b0; vid_req = 1'b0;
        settle();
        tests++; if (vid_rdata !== 16'hFFFF) begin fails++; $display("FAIL vid_collide got %h want ffff", vid_rdata); end
        tests++; if (inM !== 16'h0F0F) begin fails++; $display("FAIL cpu_after_collide got %h want 0f0f", inM); end
        tick();
        settle();
        tests++; if (vid_rvalid !== 1'b0) begin fails++; $display("FAIL vid_idle got %h want 0", vid_rvalid); end
        tests++; if (vid_rdata !== 16'hFFFF) begin fails++; $display("FAIL vid_hold got %h want ffff", vid_rdata); end
        tick();
        addressM = 15'h4000; outM = 16'h0001; writeM = 1'b1;
        tick();
        addressM = 15'h4001; outM = 16'h0002;
        tick();
        writeM = 1'b0; addressM = 15'h0000;
        vid_req = 1'b1; vid_addr = 13'h0000;
        tick();
        vid_addr = 13'h0001;
        settle();
        tests++; if (vid_rdata !== 16'h0001) begin fails++; $display("FAIL vid_b2b0 got %h want 0001", vid_rdata); end
        tick();
        vid_req = 1'b0;
        settle();
        tests++; if (vid_rvalid !== 1'b1 || vid_rdata !== 16'h0002) begin fails++; $display("FAIL vid_b2b1 got %h/%h want 1/0002", vid_rvalid, vid_rdata); end
        tick();
    endtask

    task automatic test_kbd();
        addressM = 15'h6000; kbd_valid = 1'b1; kbd_code = 16'h0041;
        settle();
        tests++; if (kbd_ready !== 1'b1) begin fails++; $display("FAIL kbd_ready_idle got %h want 1", kbd_ready); end
        tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL kbd_pre_accept got %h want 0000", inM); end
        tick();
        kbd_code = 16'h0055;
        settle();
        tests++; if (kbd_ready !== 1'b0) begin fails++; $display("FAIL kbd_cool got %h want 0", kbd_ready); end
        tests++; if (inM !== 16'h0041) begin fails++; $display("FAIL kbd_reg got %h want 0041", inM); end
        tick();
        kbd_valid = 1'b0;
        settle();
        tests++; if (kbd_ready !== 1'b1) begin fails++; $display("FAIL kbd_held_ready got %h want 1", kbd_ready); end
        tests++; if (inM !== 16'h0041) begin fails++; $display("FAIL kbd_cool_ignored got %h want 0041", inM); end
        kbd_valid = 1'b1; kbd_code = 16'h0000;
        tick();
        kbd_valid = 1'b0;
        settle();
        tests++; if (kbd_ready !== 1'b0 || inM !== 16'h0000) begin fails++; $display("FAIL kbd_release got %h/%h want 0/0000", kbd_ready, inM); end
        tick();
        settle();
        tests++; if (kbd_ready !== 1'b1) begin fails++; $display("FAIL kbd_back_idle got %h want 1", kbd_ready); end
        tick();
        addressM = 15'h0000;
    endtask

    task automatic test_unmapped();
        addressM = 15'h6000; outM = 16'hBEEF; writeM = 1'b1;
        tick();
        writeM = 1'b0;
        settle();
        tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL kbd_wr_ignored got %h want 0000", inM); end
`ifdef HACK_DATA_MEM_OOB_FLAG_EN
        tests++; if (oob_err !== 1'b0) begin fails++; $display("FAIL oob_clear got %h want 0", oob_err); end
`endif
        tick();
        addressM = 15'h7000; writeM = 1'b1;
        tick();
        writeM = 1'b0;
        settle();
        tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL unmapped_rd got %h want 0000", inM); end
`ifdef HACK_DATA_MEM_OOB_FLAG_EN
        tests++; if (oob_err !== 1'b1) begin fails++; $display("FAIL oob_set got %h want 1", oob_err); end
`endif
        tick();
        addressM = 15'h6001;
        settle();
        tests++; if (inM !== 16'h0000) begin fails++; $display("FAIL unmapped_6001 got %h want 0000", inM); end
        tick();
        addressM = 15'h0000;
    endtask

    task automatic test_reset_mid();
        addressM = 15'h0100; outM = 16'hCAFE; writeM = 1'b1;
        tick();
        writeM = 1'b0; kbd_valid = 1'b1; kbd_code = 16'h0041;
        tick();
        kbd_valid = 1'b0;
        tick();
        addressM = 15'h6000;
        settle();
        tests++; if (inM !== 16'h0041) begin fails++; $display("FAIL mid_held got %h want 0041", inM); end
        vid_req = 1'b1; vid_addr = 13'h0010;
        tick();
        addressM = 15'h0101; outM = 16'h7777; writeM = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; writeM = 1'b0; vid_req = 1'b0; addressM = 15'h6000;
        settle();
        tests++; if (vid_rvalid !== 1'b0 || vid_rdata !== 16'h0000) begin fails++; $display("FAIL mid_vid got %h/%h want 0/0000", vid_rvalid, vid_rdata); end
        tests++; if (kbd_ready !== 1'b1 || inM !== 16'h0000) begin fails++; $display("FAIL mid_kbd got %h/%h want 1/0000", kbd_ready, inM); end
`ifdef HACK_DATA_MEM_OOB_FLAG_EN
        tests++; if (oob_err !== 1'b0) begin fails++; $display("FAIL mid_oob got %h want 0", oob_err); end
`endif
        tick();
        addressM = 15'h0100;
        settle();
        tests++; if (inM !== 16'hCAFE) begin fails++; $display("FAIL mid_ram_keep got %h want cafe", inM); end
        tick();
        addressM = 15'h0101;
        settle();
        tests++; if (inM !== 16'h7777) begin fails++; $display("FAIL mid_ram_wr_on_reset got %h want 7777", inM); end
        tick();
    endtask

    initial begin
        reset = 1'b1; addressM = '0; outM = '0; writeM = 1'b0;
        vid_req = 1'b0; vid_addr = '0; kbd_valid = 1'b0; kbd_code = '0;
        test_reset();
        test_ram_rw();
        test_scanout();
        test_kbd();
        test_unmapped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
